// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared widths for the square-root datapath
package sqrt_pkg;

    localparam int DW_DEFAULT     = 16;
    localparam int ROOT_W_DEFAULT = DW_DEFAULT / 2;

    // Partial remainder carries a sign bit plus one bit of growth beyond the root.
    function automatic int rem_width(input int dw);
        return dw / 2 + 2;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one non-restoring square-root iteration (combinational)
import sqrt_pkg::*;

module sqrt_step #(
    parameter int DW = DW_DEFAULT,
    parameter int QW = DW / 2,
    parameter int RW = rem_width(DW)
) (
    input  logic [RW-1:0] r,
    input  logic [QW-1:0] q,
    input  logic [1:0]    pair,
    output logic [RW-1:0] r_next,
    output logic          q_bit
);

    logic [RW-1:0] p;
    logic [1:0]    unused_hi;

    // The two bits shifted out of r are sign copies, so dropping them loses nothing.
    assign unused_hi = r[RW-2 +: 2];
    assign p         = {r[RW-3:0], pair};

    always_comb begin
        if (r[RW-1] == 1'b0)
            r_next = p - {q, 2'b01};
        else
            r_next = p + {q, 2'b11};
        q_bit = ~r_next[RW-1];
    end

endmodule

// File: rtl/sqrt_add_unit.sv
// rtl/sqrt_add_unit.sv - iterative integer square root, one root bit per clock
import sqrt_pkg::*;

module sqrt_add_unit #(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          start,
    input  logic          ctrl,
    input  logic [DW-1:0] D,
    input  logic [DW-1:0] excounter,
    output logic [DW-1:0] Q,
    output logic [DW-1:0] remainder,
    output logic          ready
);

    localparam int QW = DW / 2;
    localparam int RW = rem_width(DW);
    localparam int IW = (QW > 1) ? $clog2(QW) : 1;
    localparam logic [DW-1:0] ITER_LIMIT = DW'(QW);

    logic [DW-1:0] dr;
    logic [QW-1:0] qr;
    logic [RW-1:0] rr;
    logic          ready_r;

    logic [IW-1:0] idx;
    logic [1:0]    pair;
    logic [RW-1:0] r_next;
    logic          q_bit;

    assign idx  = excounter[IW-1:0];
    assign pair = dr[{idx, 1'b0} +: 2];

    sqrt_step #(.DW(DW), .QW(QW), .RW(RW)) u_step (
        .r      (rr),
        .q      (qr),
        .pair   (pair),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dr      <= '0;
            qr      <= '0;
            rr      <= '0;
            ready_r <= 1'b0;
        end else if (load) begin
            dr      <= D;
            qr      <= '0;
            rr      <= '0;
            ready_r <= 1'b0;
        end else if (!ready_r) begin
            if (ctrl) begin
                // A negative remainder is off by 2Q+1; restoring it once finishes the job.
                if (rr[RW-1])
                    rr <= rr + {1'b0, qr, 1'b1};
                ready_r <= 1'b1;
            end else if (start && (excounter < ITER_LIMIT)) begin
                rr <= r_next;
                qr <= {qr[QW-2:0], q_bit};
            end
        end
    end

    always_comb begin
        Q             = '0;
        Q[QW-1:0]     = qr;
        remainder     = '0;
        remainder[RW-1:0] = rr;
    end

    assign ready = ready_r;

endmodule

// File: tb/tb_sqrt_add_unit.sv
// tb/tb_sqrt_add_unit.sv - directed self-checking bench for sqrt_add_unit
module tb_sqrt_add_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        start = 1'b0;
    logic        ctrl = 1'b0;
    logic [15:0] D = '0;
    logic [15:0] excounter = '0;
    logic [15:0] Q;
    logic [15:0] remainder;
    logic        ready;

    int errors = 0;
    int checks = 0;

    sqrt_add_unit #(.DW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .start     (start),
        .ctrl      (ctrl),
        .D         (D),
        .excounter (excounter),
        .Q         (Q),
        .remainder (remainder),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] d);
        D = d; load = 1'b1; start = 1'b0; ctrl = 1'b0;
        tick();
        load = 1'b0;
    endtask

    task automatic iterate(input int from, input int to);
        start = 1'b1;
        for (int e = from; e >= to; e--) begin
            excounter = 16'(e);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input logic [15:0] eq, input logic [15:0] er);
        check({tag, "_ready_pre"}, {15'd0, ready}, 16'd0);
        ctrl = 1'b1;
        tick();
        ctrl = 1'b0;
        check({tag, "_q"}, Q, eq);
        check({tag, "_rem"}, remainder, er);
        check({tag, "_ready"}, {15'd0, ready}, 16'd1);
    endtask

    task automatic full_run(input string tag, input logic [15:0] d,
                            input logic [15:0] eq, input logic [15:0] er);
        do_load(d);
        iterate(7, 0);
        finish_run(tag, eq, er);
    endtask

    initial begin
        #12;
        check("rst_q", Q, 16'd0);
        check("rst_rem", remainder, 16'd0);
        check("rst_ready", {15'd0, ready}, 16'd0);
        reset = 1'b0;
        tick();

        // D=127 with the idle index-8 cycle first
        do_load(16'd127);
        check("ld127_ready", {15'd0, ready}, 16'd0);
        iterate(8, 8);
        check("idle8_q", Q, 16'd0);
        check("idle8_rem", remainder, 16'd0);
        iterate(7, 0);
        finish_run("d127", 16'd11, 16'd6);

        // Frozen after ready: start/ctrl/excounter wiggling must not disturb the result
        for (int k = 0; k < 4; k++) begin
            start = k[0]; ctrl = k[1]; excounter = 16'(k * 3);
            tick();
        end
        start = 1'b0; ctrl = 1'b0;
        check("hold_q", Q, 16'd11);
        check("hold_rem", remainder, 16'd6);
        check("hold_ready", {15'd0, ready}, 16'd1);

        full_run("d49", 16'd49, 16'd7, 16'd0);
        full_run("d0", 16'd0, 16'd0, 16'd0);
        full_run("d65535", 16'd65535, 16'd255, 16'd510);
        full_run("d16", 16'd16, 16'd4, 16'd0);
        full_run("d120", 16'd120, 16'd10, 16'd20);

        // Stall after three iterations: top root bits of 65535 are 3'b111
        do_load(16'd65535);
        iterate(7, 5);
        check("stall_q0", Q, 16'd7);
        excounter = 16'd4;
        for (int k = 0; k < 3; k++) tick();
        check("stall_q3", Q, 16'd7);
        iterate(4, 0);
        finish_run("stall", 16'd255, 16'd510);

        // ctrl beats start: after load, ctrl with start yields ready and untouched zero state
        do_load(16'd127);
        start = 1'b1; ctrl = 1'b1; excounter = 16'd7;
        tick();
        start = 1'b0; ctrl = 1'b0;
        check("prio_q", Q, 16'd0);
        check("prio_rem", remainder, 16'd0);
        check("prio_ready", {15'd0, ready}, 16'd1);

        // Async reset after iteration 4; remainder is -1 (all ones in 10 bits) beforehand
        do_load(16'd127);
        iterate(7, 4);
        check("pre_rst_rem", remainder, 16'h03FF);
        #2 reset = 1'b1;
        #1;
        check("arst_q", Q, 16'd0);
        check("arst_rem", remainder, 16'd0);
        check("arst_ready", {15'd0, ready}, 16'd0);
        tick();
        reset = 1'b0;
        full_run("rerun127", 16'd127, 16'd11, 16'd6);

        // Load during iteration restarts with the new radicand
        do_load(16'd65535);
        iterate(7, 3);
        full_run("reload16", 16'd16, 16'd4, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
